dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU A / DMA B) data-memory arbiter with round-robin tie break and bounded bursts; grant 1 cycle after req, rdata/rvalid 1 cycle after a read ack.
// Backpressure: a requester holds req until ack; the loser of a tie or a burst-limited port simply waits.
module dmem_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_MW,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] burst_cnt;
    logic [3:0] burst_nxt;
    logic       last_b;
    logic       burst_room;
    logic [3:0] burst_inc;

    // Outputs depend on req only inside a registered grant, so reset forcing IDLE clears them at once.
    always_comb begin
        ack_a       = 1'b0;
        ack_b       = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_MW      = 1'b0;
        case (state)
            GNT_A: begin
                ack_a       = req_a;
                mem_addr    = addr_a;
                mem_data_in = wdata_a;
                mem_MW      = req_a & we_a;
            end
            GNT_B: begin
                ack_b       = req_b;
                mem_addr    = addr_b;
                mem_data_in = wdata_b;
                mem_MW      = req_b & we_b;
            end
            default: ;
        endcase
    end

    assign burst_room = ({1'b0, burst_cnt} + 5'd1) < 5'(BURST_MAX);
    // Saturate so a long uncontended run cannot wrap and hand out a fresh burst.
    assign burst_inc  = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                burst_nxt = 4'd0;
                if (req_a && (!req_b || last_b))
                    state_nxt = GNT_A;
                else if (req_b)
                    state_nxt = GNT_B;
            end
            GNT_A: begin
                if (req_a) begin
                    if (!req_b || burst_room) begin
                        burst_nxt = burst_inc;
                    end else begin
                        state_nxt = GNT_B;
                        burst_nxt = 4'd0;
                    end
                end else begin
                    state_nxt = req_b ? GNT_B : IDLE;
                    burst_nxt = 4'd0;
                end
            end
            GNT_B: begin
                if (req_b) begin
                    if (!req_a || burst_room) begin
                        burst_nxt = burst_inc;
                    end else begin
                        state_nxt = GNT_A;
                        burst_nxt = 4'd0;
                    end
                end else begin
                    state_nxt = req_a ? GNT_A : IDLE;
                    burst_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
            last_b    <= 1'b1;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (ack_a)
                last_b <= 1'b0;
            else if (ack_b)
                last_b <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rdata_a  <= '0;
            rdata_b  <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= ack_a & ~we_a;
            rvalid_b <= ack_b & ~we_b;
            if (ack_a && !we_a)
                rdata_a <= mem_out;
            if (ack_b && !we_b)
                rdata_b <= mem_out;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural 64-word memory, hand-computed expectations.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req_a, req_b, we_a, we_b;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        ack_a, ack_b, rvalid_a, rvalid_b, mem_MW;
    logic [31:0] rdata_a, rdata_b, mem_data_in, mem_out;
    logic [5:0]  mem_addr;

    logic [31:0] mem [64];
    logic        mem_loaded;
    int          n_chk = 0;
    int          n_err = 0;

    dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .BURST_MAX(4)) dut (
        .CLK(CLK), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .mem_addr(mem_addr), .mem_MW(mem_MW), .mem_data_in(mem_data_in),
        .mem_out(mem_out)
    );

    always #5 CLK = ~CLK;

    // Memory preloads mem[i] = i, then behaves as a synchronous-write, async-read RAM.
    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (mem_MW) begin
            mem[mem_addr] <= mem_data_in;
        end
    end
    assign mem_out = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] exp_code;
        reset = 1'b0; mem_loaded = 1'b0;
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        repeat (2) @(posedge CLK);
        mem_loaded = 1'b1;

        // Reset state
        @(negedge CLK);
        check("rst_ack_a",   32'(ack_a),    32'd0);
        check("rst_ack_b",   32'(ack_b),    32'd0);
        check("rst_mw",      32'(mem_MW),   32'd0);
        check("rst_addr",    32'(mem_addr), 32'd0);
        check("rst_rdata_a", rdata_a,       32'd0);
        check("rst_rvalid_a",32'(rvalid_a), 32'd0);
        tick(); reset = 1'b1;

        // Single read of addr 5 by A
        req_a = 1; we_a = 0; addr_a = 6'd5;
        @(negedge CLK); check("rd_c0_ack", 32'(ack_a), 32'd0);
        tick(); @(negedge CLK);
        check("rd_c1_ack",  32'(ack_a),    32'd1);
        check("rd_c1_addr", 32'(mem_addr), 32'd5);
        check("rd_c1_mw",   32'(mem_MW),   32'd0);
        tick(); req_a = 0; @(negedge CLK);
        check("rd_c2_rvalid", 32'(rvalid_a), 32'd1);
        check("rd_c2_rdata",  rdata_a,       32'd5);
        check("rd_c2_ack",    32'(ack_a),    32'd0);
        tick(); @(negedge CLK);
        check("rd_c3_rvalid", 32'(rvalid_a), 32'd0);
        check("rd_c3_hold",   rdata_a,       32'd5);

        // Single write by B of DEADBEEF to addr 63
        tick(); req_b = 1; we_b = 1; addr_b = 6'd63; wdata_b = 32'hDEADBEEF;
        @(negedge CLK);
        check("wr_c0_mw",  32'(mem_MW), 32'd0);
        check("wr_c0_ack", 32'(ack_b),  32'd0);
        tick(); @(negedge CLK);
        check("wr_c1_ack",  32'(ack_b),    32'd1);
        check("wr_c1_mw",   32'(mem_MW),   32'd1);
        check("wr_c1_addr", 32'(mem_addr), 32'd63);
        check("wr_c1_data", mem_data_in,   32'hDEADBEEF);
        tick(); req_b = 0; we_b = 0; @(negedge CLK);
        check("wr_c2_mw",     32'(mem_MW),   32'd0);
        check("wr_c2_rvalid", 32'(rvalid_b), 32'd0);

        // Tie after a B-only access goes to A; A then withdraws while B waits
        tick(); req_a = 1; addr_a = 6'd63; req_b = 1; addr_b = 6'd5;
        @(negedge CLK); check("tie_c0_none", {30'd0, ack_b, ack_a}, 32'd0);
        tick(); @(negedge CLK);
        check("tie_c1_ack_a", 32'(ack_a), 32'd1);
        check("tie_c1_ack_b", 32'(ack_b), 32'd0);
        tick(); req_a = 0; @(negedge CLK);
        check("tie_c2_rdata",  rdata_a,        32'hDEADBEEF);
        check("tie_c2_rvalid", 32'(rvalid_a),  32'd1);
        check("wd_c2_none",    {30'd0, ack_b, ack_a}, 32'd0);
        tick(); @(negedge CLK);
        check("wd_c3_ack_b", 32'(ack_b),    32'd1);
        check("wd_c3_addr",  32'(mem_addr), 32'd5);
        tick(); req_b = 0; @(negedge CLK);
        check("wd_c4_rvalid_b", 32'(rvalid_b), 32'd1);
        check("wd_c4_rdata_b",  rdata_b,       32'd5);

        // Continuous contention from reset: AAAABBBBAAAA
        tick(); reset = 1'b0;
        tick(); reset = 1'b1;
        req_a = 1; req_b = 1; addr_a = 6'd1; addr_b = 6'd2;
        @(negedge CLK); check("ct_c0_none", {30'd0, ack_b, ack_a}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            exp_code = (((i / 4) % 2) == 0) ? 32'd1 : 32'd2;
            tick(); @(negedge CLK);
            check($sformatf("ct_c%0d", i + 1), {30'd0, ack_b, ack_a}, exp_code);
        end
        tick(); req_a = 0; req_b = 0;
        repeat (2) tick();

        // Reset pulsed mid B write burst
        req_b = 1; we_b = 1; addr_b = 6'd10; wdata_b = 32'h000000A1;
        tick(); @(negedge CLK);
        check("rb_c1_mw", 32'(mem_MW), 32'd1);
        tick(); addr_b = 6'd11; wdata_b = 32'h000000B2; @(negedge CLK);
        check("rb_c2_mw",   32'(mem_MW),   32'd1);
        check("rb_c2_addr", 32'(mem_addr), 32'd11);
        #2 reset = 1'b0;
        #1;
        check("rb_async_mw",    32'(mem_MW),   32'd0);
        check("rb_async_ack",   32'(ack_b),    32'd0);
        check("rb_async_addr",  32'(mem_addr), 32'd0);
        check("rb_async_data",  mem_data_in,   32'd0);
        check("rb_async_rdata", rdata_b,       32'd0);
        tick(); reset = 1'b1; req_b = 0; we_b = 0;
        check("rb_mem10", mem[10], 32'h000000A1);
        check("rb_mem11", mem[11], 32'd11);
        req_a = 1; addr_a = 6'd11;
        @(negedge CLK); check("rb_idle_ack", 32'(ack_a), 32'd0);
        tick(); @(negedge CLK); check("rb_gnt_ack", 32'(ack_a), 32'd1);
        tick(); req_a = 0; @(negedge CLK);
        check("rb_rd11", rdata_a, 32'd11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
